// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment patterns, result codes and scan states for seg_scan_decoder
package seg_pkg;

    // Patterns are seg[6:0] = g..a, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational seven-segment pattern to BCD code lookup
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       known
);

    always_comb begin
        known = 1'b1;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code  = CODE_ERR;
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - multiplexed seven-segment bus readback; SEG_DP_CAPTURE_EN adds decimal-point capture
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    seg,
    input  logic [NUM_DIGITS-1:0]         an,
    output logic [4*NUM_DIGITS-1:0]       digits,
    output logic [NUM_DIGITS-1:0]         dp,
    output logic [NUM_DIGITS-1:0]         err,
    output logic                          upd,
    output logic [$clog2(NUM_DIGITS)-1:0] upd_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

`ifdef SEG_DP_CAPTURE_EN
    localparam int SEG_W = 8;
`else
    // Decimal point is not part of the sample at all in this build
    localparam int SEG_W = 7;
    logic unused_seg_dp;
    assign unused_seg_dp = seg[7];
`endif

    logic [SEG_W-1:0]      seg_meta, seg_s, seg_prev;
    logic [NUM_DIGITS-1:0] an_meta, an_s, an_prev;

    // Reset to all-ones: blank segments, no digit selected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_meta <= '1;
            seg_s    <= '1;
            seg_prev <= '1;
            an_meta  <= '1;
            an_s     <= '1;
            an_prev  <= '1;
        end else begin
            seg_meta <= seg[SEG_W-1:0];
            seg_s    <= seg_meta;
            seg_prev <= seg_s;
            an_meta  <= an;
            an_s     <= an_meta;
            an_prev  <= an_s;
        end
    end

    logic             an_valid;
    logic             stable;
    logic [IDX_W-1:0] sel_idx;
    logic [3:0]       code;
    logic             known;
    logic             capture;
    scan_state_t      state;
    logic [7:0]       cnt;

    assign an_valid = $onehot(~an_s);
    assign stable   = (seg_s == seg_prev) && (an_s == an_prev);
    assign capture  = (state == SETTLE) && an_valid && stable && (cnt == CNT_LAST);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) sel_idx = IDX_W'(i);
        end
    end

    seg_pattern_decode u_decode (
        .pattern (seg_s[6:0]),
        .code    (code),
        .known   (known)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            digits  <= {NUM_DIGITS{CODE_BLANK}};
            err     <= '0;
            upd     <= 1'b0;
            upd_idx <= '0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (an_valid) state <= SETTLE;
                end
                SETTLE: begin
                    if (!an_valid) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!stable) begin
                        cnt <= '0;
                    end else if (capture) begin
                        state                  <= HOLD;
                        cnt                    <= '0;
                        digits[4*sel_idx +: 4] <= code;
                        err[sel_idx]           <= err[sel_idx] | ~known;
                        upd                    <= 1'b1;
                        upd_idx                <= sel_idx;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    // One capture per dwell: only a change of sample re-arms settling
                    if (!an_valid) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!stable) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp <= '0;
        end else if (capture) begin
            dp[sel_idx] <= ~seg_s[SEG_W-1];
        end
    end
`else
    assign dp = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder with a run-length reference model
module tb_seg_scan_decoder;

    localparam int N = 4;
    localparam int S = 4;
`ifdef SEG_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic [7:0]     seg_pin = 8'hFF;
    logic [N-1:0]   an_pin  = '1;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp;
    logic [N-1:0]   err;
    logic           upd;
    logic [1:0]     upd_idx;

    seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .seg     (seg_pin),
        .an      (an_pin),
        .digits  (digits),
        .dp      (dp),
        .err     (err),
        .upd     (upd),
        .upd_idx (upd_idx)
    );

    always #5 clk = ~clk;

    int         n_checks     = 0;
    int         n_fail       = 0;
    int         cyc          = 0;
    int         upd_seen     = 0;
    int         last_upd_cyc = 0;
    int         min_gap      = 1000;
    logic [1:0] last_idx     = '0;
    int         div_cnt      = 0;
    string      div_msg      = "";

    logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'h7F) return {1'b1, 4'hF};
        for (int k = 0; k < 10; k++) begin
            if (p == pat_tab[k]) return {1'b1, 4'(k)};
        end
        return {1'b0, 4'hE};
    endfunction

    function automatic int zero_pos(input logic [N-1:0] a);
        for (int k = 0; k < N; k++) begin
            if (a[k] == 1'b0) return k;
        end
        return 0;
    endfunction

    // Reference: a capture fires when the pin key has held for S+1 samples on a
    // single selected digit, and becomes visible two clocks later (synchronizer).
    logic [N+7:0]   m_prev;
    int             m_run;
    logic           d1_v, d2_v;
    logic [N-1:0]   d1_an, d2_an;
    logic [7:0]     d1_seg, d2_seg;
    logic           m_upd;
    logic [1:0]     m_idx;
    logic [4*N-1:0] m_digits;
    logic [N-1:0]   m_dp, m_err;
    int             m_upd_cnt = 0;
    logic [N+7:0]   cur_key;
    int             nrun;
    logic           cap_now;
    logic [4:0]     d2_dec;
    int             d2_pos;

    assign cur_key = {an_pin, (DP_EN ? seg_pin[7] : 1'b0), seg_pin[6:0]};
    assign nrun    = (cur_key == m_prev) ? m_run + 1 : 1;
    assign cap_now = (nrun == S + 1) && ($countones(~an_pin) == 1);
    assign d2_dec  = ref_decode(d2_seg[6:0]);
    assign d2_pos  = zero_pos(d2_an);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_prev   <= {{N{1'b1}}, DP_EN, 7'h7F};
            m_run    <= 0;
            d1_v     <= 1'b0;
            d2_v     <= 1'b0;
            d1_an    <= '1;
            d2_an    <= '1;
            d1_seg   <= '1;
            d2_seg   <= '1;
            m_upd    <= 1'b0;
            m_idx    <= '0;
            m_digits <= '1;
            m_dp     <= '0;
            m_err    <= '0;
        end else begin
            m_prev    <= cur_key;
            m_run     <= (nrun > 1000) ? 1000 : nrun;
            d1_v      <= cap_now;
            d1_an     <= an_pin;
            d1_seg    <= seg_pin;
            d2_v      <= d1_v;
            d2_an     <= d1_an;
            d2_seg    <= d1_seg;
            m_upd     <= d2_v;
            m_upd_cnt <= m_upd_cnt + (d2_v ? 1 : 0);
            if (d2_v) begin
                m_idx                  <= 2'(d2_pos);
                m_digits[4*d2_pos +: 4] <= d2_dec[3:0];
                if (!d2_dec[4]) m_err[d2_pos] <= 1'b1;
                if (DP_EN) m_dp[d2_pos] <= ~d2_seg[7];
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (upd === 1'b1) begin
                if (upd_seen > 0 && (cyc - last_upd_cyc) < min_gap) min_gap = cyc - last_upd_cyc;
                upd_seen++;
                last_idx     = upd_idx;
                last_upd_cyc = cyc;
            end
            if (upd !== m_upd || digits !== m_digits || dp !== m_dp || err !== m_err ||
                (m_upd === 1'b1 && upd_idx !== m_idx)) begin
                if (div_cnt == 0)
                    div_msg = $sformatf("cyc %0d upd %b/%b idx %0d/%0d digits %h/%h dp %b/%b err %b/%b",
                                        cyc, upd, m_upd, upd_idx, m_idx, digits, m_digits, dp, m_dp, err, m_err);
                div_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        int d0;
        reset_n = 1'b0;
        an_pin  = 4'b1111;
        seg_pin = 8'hFF;
        tick(3);
        reset_n  = 1'b1;
        upd_seen = 0;
        d0       = div_cnt;
        tick(8);
        n_checks++;
        if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL reset_digits: got %h expected ffff", digits); end
        n_checks++;
        if (dp !== 4'b0000) begin n_fail++; $display("FAIL reset_dp: got %b expected 0000", dp); end
        n_checks++;
        if (err !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b expected 0000", err); end
        n_checks++;
        if (upd_seen !== 0 || upd_idx !== 2'd0) begin
            n_fail++; $display("FAIL reset_upd: got %0d pulses idx %0d expected 0 pulses idx 0", upd_seen, upd_idx);
        end
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL reset_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    task automatic test_single_capture();
        int c0, d0;
        upd_seen = 0;
        d0       = div_cnt;
        c0       = cyc;
        an_pin   = 4'b1110;
        seg_pin  = 8'b10100100;
        tick(10);
        n_checks++;
        if (upd_seen !== 1) begin n_fail++; $display("FAIL single_count: got %0d pulses expected 1", upd_seen); end
        n_checks++;
        if (last_idx !== 2'd0) begin n_fail++; $display("FAIL single_idx: got %0d expected 0", last_idx); end
        n_checks++;
        if (last_upd_cyc - c0 !== S + 3) begin
            n_fail++; $display("FAIL single_latency: got %0d edges expected %0d", last_upd_cyc - c0, S + 3);
        end
        n_checks++;
        if (digits[3:0] !== 4'd2) begin n_fail++; $display("FAIL single_value: got %h expected 2", digits[3:0]); end
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL single_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    task automatic test_scan();
        int vals[4] = '{9, 0, 7, 1};
        int d0;
        upd_seen = 0;
        d0       = div_cnt;
        for (int i = 0; i < N; i++) begin
            an_pin    = '1;
            an_pin[i] = 1'b0;
            seg_pin   = {(i == 1) ? 1'b0 : 1'b1, pat_tab[vals[i]]};
            tick(8);
        end
        an_pin  = '1;
        seg_pin = 8'hFF;
        tick(8);
        n_checks++;
        if (digits !== 16'h1709) begin n_fail++; $display("FAIL scan_digits: got %h expected 1709", digits); end
        n_checks++;
        if (dp !== (DP_EN ? 4'b0010 : 4'b0000)) begin
            n_fail++; $display("FAIL scan_dp: got %b expected %b", dp, DP_EN ? 4'b0010 : 4'b0000);
        end
        n_checks++;
        if (upd_seen !== 4) begin n_fail++; $display("FAIL scan_count: got %0d pulses expected 4", upd_seen); end
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL scan_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    task automatic test_glitch();
        int d0;
        upd_seen = 0;
        d0       = div_cnt;
        an_pin   = 4'b1101;
        seg_pin  = 8'hFF;
        tick(8);
        seg_pin = 8'b10000000;
        tick(2);
        seg_pin = 8'hFF;
        tick(8);
        an_pin = '1;
        tick(6);
        n_checks++;
        if (digits[7:4] !== 4'hF) begin n_fail++; $display("FAIL glitch_value: got %h expected f", digits[7:4]); end
        n_checks++;
        if (upd_seen !== 2) begin n_fail++; $display("FAIL glitch_count: got %0d pulses expected 2 (blank twice)", upd_seen); end
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL glitch_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    task automatic test_illegal();
        int d0;
        d0      = div_cnt;
        an_pin  = 4'b0111;
        seg_pin = 8'b11010101;
        tick(8);
        n_checks++;
        if (digits[15:12] !== 4'hE || err !== 4'b1000) begin
            n_fail++; $display("FAIL illegal_capture: got code %h err %b expected e 1000", digits[15:12], err);
        end
        seg_pin = {1'b1, pat_tab[5]};
        tick(8);
        n_checks++;
        if (digits[15:12] !== 4'd5 || err !== 4'b1000) begin
            n_fail++; $display("FAIL illegal_sticky: got code %h err %b expected 5 1000", digits[15:12], err);
        end
        an_pin = '1;
        tick(6);
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL illegal_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    task automatic test_reset_mid();
        int d0, c0;
        d0       = div_cnt;
        upd_seen = 0;
        an_pin   = 4'b1011;
        seg_pin  = {1'b0, pat_tab[3]};
        tick(4);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (digits !== 16'hFFFF || err !== 4'b0000 || dp !== 4'b0000 || upd !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got digits %h err %b dp %b upd %b expected ffff 0000 0000 0",
                               digits, err, dp, upd);
        end
        tick(3);
        reset_n = 1'b1;
        c0      = cyc;
        tick(10);
        n_checks++;
        if (upd_seen !== 1 || last_upd_cyc - c0 !== S + 3) begin
            n_fail++; $display("FAIL midreset_restart: got %0d pulses at %0d edges expected 1 at %0d",
                               upd_seen, last_upd_cyc - c0, S + 3);
        end
        n_checks++;
        if (digits !== 16'hF3FF || dp !== (DP_EN ? 4'b0100 : 4'b0000)) begin
            n_fail++; $display("FAIL midreset_value: got %h dp %b expected f3ff dp %b", digits, dp, DP_EN ? 4'b0100 : 4'b0000);
        end
        an_pin = '1;
        tick(6);
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL midreset_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    task automatic test_back_to_back();
        int vals[4] = '{3, 8, 6, 4};
        int d0;
        d0       = div_cnt;
        upd_seen = 0;
        min_gap  = 1000;
        for (int i = 0; i < N; i++) begin
            an_pin    = '1;
            an_pin[i] = 1'b0;
            seg_pin   = {1'b1, pat_tab[vals[i]]};
            tick(S + 1);
        end
        an_pin = '1;
        tick(8);
        n_checks++;
        if (upd_seen !== 4 || min_gap < S) begin
            n_fail++; $display("FAIL b2b_pulses: got %0d pulses min gap %0d expected 4 gap >= %0d", upd_seen, min_gap, S);
        end
        n_checks++;
        if (digits !== 16'h4683) begin n_fail++; $display("FAIL b2b_digits: got %h expected 4683", digits); end
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL b2b_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    task automatic test_random();
        int d0, u0, m0, r;
        d0       = div_cnt;
        upd_seen = 0;
        m0       = m_upd_cnt;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 7);
            if (r == 0) an_pin = '1;
            else if (r == 1) an_pin = 4'($urandom);
            else begin
                an_pin = '1;
                an_pin[$urandom_range(0, N - 1)] = 1'b0;
            end
            r = $urandom_range(0, 11);
            if (r < 10) seg_pin[6:0] = pat_tab[r];
            else if (r == 10) seg_pin[6:0] = 7'h7F;
            else seg_pin[6:0] = 7'($urandom);
            seg_pin[7] = 1'($urandom);
            tick($urandom_range(1, 9));
        end
        an_pin  = '1;
        seg_pin = 8'hFF;
        tick(8);
        u0 = m_upd_cnt - m0;
        n_checks++;
        if (upd_seen !== u0) begin n_fail++; $display("FAIL random_count: got %0d pulses expected %0d", upd_seen, u0); end
        n_checks++;
        if (div_cnt - d0 !== 0) begin n_fail++; $display("FAIL random_model: %0d diffs, first %s", div_cnt - d0, div_msg); end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_scan();
        test_glitch();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart to the seven-segment encoder. The block samples a time-multiplexed, active-low seven-segment bus (shared segment lines plus per-digit active-low select lines) and recovers the BCD value shown on each digit into a register bank. It sits in test and loopback paths, where it reads back what the display drivers emit. A stability filter rejects transitions and ghosting while the scan changes digits.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits and the width of `an`.
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before capture. Legal range is 2..255.
- clk  input  1: system clock. All logic is on the rising edge.
- reset_n  input  1: asynchronous active-low reset. Release is synchronous to `clk`.
- seg  input  8: active-low segment bus. Bit 7 is the decimal point; bits 6:0 are segments g..a. Asynchronous to `clk`.
- an  input  NUM_DIGITS: active-low digit select, one-hot-low when valid. Asynchronous to `clk`.
- digits  output  4*NUM_DIGITS: decoded codes. Digit i occupies bits [4i+3:4i].
- dp  output  NUM_DIGITS: captured decimal-point state, 1 = lit.
- err  output  NUM_DIGITS: sticky per-digit flag for an unrecognized pattern.
- upd  output  1: one-cycle pulse when a digit is captured.
- upd_idx  output  $clog2(NUM_DIGITS): index of the digit captured. Valid only while `upd` = 1.

## Operation
- `seg` and `an` each pass through a 2-flop synchronizer. The resulting pair is the sample `s`.
- Decode map from `seg[6:0]` to code:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9.
  - 1111111→4'hF (blank).
  - Any other pattern → 4'hE and sets `err[i]`.
- State machine, states IDLE, SETTLE, HOLD:
  - IDLE: `an` in `s` is not one-hot-low (all high, or more than one low). The counter is held at 0. A one-hot-low `an` moves to SETTLE.
  - SETTLE: the counter increments each cycle `s` equals the previous `s`. Any difference resets the counter to 0 and stays in SETTLE. An invalid `an` goes to IDLE. When the count reaches STABLE_CYCLES−1, the block captures and goes to HOLD.
  - Capture: writes `digits[i]`, `dp[i]`, ORs into `err[i]` when the pattern is unrecognized, and pulses `upd` with `upd_idx` = i.
  - HOLD: no further capture while `s` is unchanged. Any change goes to SETTLE with the counter at 0, or to IDLE if `an` is invalid. This gives exactly one capture per dwell.
- Digits not currently selected keep their last value.
- `err` bits clear only on reset.

## Timing
- Reset values:
  - `digits` = all 4'hF.
  - `dp` = 0, `err` = 0, `upd` = 0, `upd_idx` = 0.
  - State is IDLE and the counter is 0.
- Latency: pins stable from edge t produce `upd` = 1 and updated `digits`/`dp`/`err` in the cycle after edge t+STABLE_CYCLES+2. That is STABLE_CYCLES+3 edges.
- `upd` is high for exactly one cycle per capture. Back-to-back captures of different digits are at least STABLE_CYCLES cycles apart.
- A change of `seg` alone, with the same digit selected, restarts settling and recaptures that digit.
- A glitch shorter than STABLE_CYCLES samples never causes a capture.
- Reset asserted mid-SETTLE or mid-HOLD: all outputs go to their reset values immediately. Synchronizer flops reset to all-ones (blank, no digit selected).

## Configuration
- SEG_DP_CAPTURE_EN defined:
  - `seg[7]` takes part in the stability comparison.
  - It is captured inverted into `dp[i]`.
- SEG_DP_CAPTURE_EN undefined:
  - `seg[7]` is not synchronized and is ignored for stability.
  - `dp` is tied to 0.
  - A decimal-point-only toggle does not restart settling.

## Structure
- Package `seg_pkg` holds:
  - Segment pattern localparams SEG_0..SEG_9 and SEG_BLANK.
  - Codes CODE_BLANK = 4'hF and CODE_ERR = 4'hE.
  - The state enum {IDLE, SETTLE, HOLD}.
- Sub-module `seg_pattern_decode`: combinational `seg[6:0]` → {code[3:0], known}. The top module instantiates it once on the synchronized sample.
- The top module contains the synchronizer, counter, FSM and register bank.

## Test plan
- Reset with `an` = 4'b1111, then release → `digits` = 16'hFFFF, `dp` = 0, `err` = 0, no `upd`.
- `an` = 4'b1110, `seg` = 8'b10100100, held 10 cycles → exactly one `upd`, with `upd_idx` = 0, `digits[3:0]` = 2, and the pulse 7 edges after the pin change.
- Scan 4 digits showing 9,0,7,1, dwell 8 cycles each with `seg[7]` = 0 on digit 1 → `digits` = 16'h1709. `dp` = 4'b0010 with SEG_DP_CAPTURE_EN, 0 without.
- `an` = 4'b1101, `seg` = 8'b11111111 then a 2-cycle glitch to 8'b10000000 → no capture of 8, `digits[7:4]` = F.
- `an` = 4'b0111, `seg` = 8'b11010101 (illegal) → `digits[15:12]` = E and `err[3]` = 1. A following legal 5 updates the digit to 5, and `err[3]` stays 1.
- Assert reset 2 cycles into SETTLE → no `upd`. After release, outputs are at reset values and capture restarts normally.
